// File: rtl/ad9945_cfg_ctrl.sv
// rtl/ad9945_cfg_ctrl.sv - AD9945 shadow-register arbiter and serial-write sequencer
module ad9945_cfg_ctrl #(
  parameter int         XFER_CYCLES = 56,
  parameter int         INIT_DELAY  = 1024,
  parameter logic [6:0] DEF_OPER    = 7'h00,
  parameter logic [6:0] DEF_CTRL    = 7'h00,
  parameter logic [7:0] DEF_CLAMP   = 8'd128,
  parameter logic [9:0] DEF_GAIN    = 10'd0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        host_wr,
  input  logic [1:0]  host_sel,
  input  logic [9:0]  host_wdata,
  output logic        host_ack,
  input  logic        agc_req,
  input  logic [9:0]  agc_gain,
  output logic        agc_ack,
  input  logic        frame_sync,
  input  logic        sync_mode,
  output logic [6:0]  Oper,
  output logic [6:0]  Ctrl,
  output logic [7:0]  Clamp,
  output logic [9:0]  VGA_Gain,
  output logic        cfg_en,
  output logic        busy,
  output logic        cfg_done,
  output logic [15:0] cfg_count
);

  localparam int CNT_MAX = (INIT_DELAY > XFER_CYCLES) ? INIT_DELAY : XFER_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_IDLE,
    S_LOAD,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [6:0]     pend_oper_q, pend_oper_d;
  logic [6:0]     pend_ctrl_q, pend_ctrl_d;
  logic [7:0]     pend_clamp_q, pend_clamp_d;
  logic [9:0]     pend_gain_q, pend_gain_d;
  logic [6:0]     act_oper_q;
  logic [6:0]     act_ctrl_q;
  logic [7:0]     act_clamp_q;
  logic [9:0]     act_gain_q;
  logic           dirty_q, dirty_d;
  logic           sync_pend_q, sync_pend_d;
  logic           host_ack_q;
  logic           agc_ack_q;
  logic [15:0]    cfg_count_q, cfg_count_d;
  logic           host_gain_wr;
  logic           agc_take;
  logic           launch;

  // Host gain write beats the AGC; the AGC holds its request and retries.
  always_comb begin
    host_gain_wr = host_wr && (host_sel == 2'd3);
    agc_take     = agc_req && !host_gain_wr;
    pend_oper_d  = pend_oper_q;
    pend_ctrl_d  = pend_ctrl_q;
    pend_clamp_d = pend_clamp_q;
    pend_gain_d  = pend_gain_q;
    if (host_wr) begin
      case (host_sel)
        2'd0: pend_oper_d  = host_wdata[6:0];
        2'd1: pend_ctrl_d  = host_wdata[6:0];
        2'd2: pend_clamp_d = host_wdata[7:0];
        2'd3: pend_gain_d  = host_wdata;
      endcase
    end
    if (agc_take) begin
      pend_gain_d = agc_gain;
    end
    dirty_d = dirty_q;
    if (state_q == S_LOAD) begin
      dirty_d = 1'b0;
    end
    if (host_wr || agc_take) begin
      dirty_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_INIT_WAIT: begin
        if (cnt_q == CW'(INIT_DELAY - 1)) state_d = S_LOAD;
        else                              cnt_d   = cnt_q + 1'b1;
      end
      S_IDLE: begin
        if (dirty_q && (!sync_mode || frame_sync || sync_pend_q)) state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_PULSE;
      S_PULSE: begin
        if (cnt_q == CW'(1)) state_d = S_WAIT;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      S_WAIT: begin
        if (cnt_q == CW'(XFER_CYCLES - 1)) state_d = S_DONE;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT_WAIT;
    endcase

    launch      = (state_d == S_LOAD) && (state_q != S_LOAD);
    sync_pend_d = sync_pend_q;
    if (frame_sync && (state_q != S_IDLE)) sync_pend_d = 1'b1;
    if (launch)                            sync_pend_d = 1'b0;
    cfg_count_d = cfg_count_q;
    if (state_q == S_DONE) cfg_count_d = cfg_count_q + 16'd1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_INIT_WAIT;
      cnt_q        <= '0;
      pend_oper_q  <= DEF_OPER;
      pend_ctrl_q  <= DEF_CTRL;
      pend_clamp_q <= DEF_CLAMP;
      pend_gain_q  <= DEF_GAIN;
      act_oper_q   <= DEF_OPER;
      act_ctrl_q   <= DEF_CTRL;
      act_clamp_q  <= DEF_CLAMP;
      act_gain_q   <= DEF_GAIN;
      dirty_q      <= 1'b1;
      sync_pend_q  <= 1'b0;
      host_ack_q   <= 1'b0;
      agc_ack_q    <= 1'b0;
      cfg_count_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_oper_q  <= pend_oper_d;
      pend_ctrl_q  <= pend_ctrl_d;
      pend_clamp_q <= pend_clamp_d;
      pend_gain_q  <= pend_gain_d;
      // Active set copies the pending set as it stood before this edge's writes.
      if (state_q == S_LOAD) begin
        act_oper_q  <= pend_oper_q;
        act_ctrl_q  <= pend_ctrl_q;
        act_clamp_q <= pend_clamp_q;
        act_gain_q  <= pend_gain_q;
      end
      dirty_q      <= dirty_d;
      sync_pend_q  <= sync_pend_d;
      host_ack_q   <= host_wr;
      agc_ack_q    <= agc_take;
      cfg_count_q  <= cfg_count_d;
    end
  end

  assign Oper      = act_oper_q;
  assign Ctrl      = act_ctrl_q;
  assign Clamp     = act_clamp_q;
  assign VGA_Gain  = act_gain_q;
  assign cfg_en    = (state_q == S_PULSE);
  assign busy      = (state_q != S_IDLE);
  assign cfg_done  = (state_q == S_DONE);
  assign cfg_count = cfg_count_q;
  assign host_ack  = host_ack_q;
  assign agc_ack   = agc_ack_q;

endmodule

// File: tb/tb_ad9945_cfg_ctrl.sv
// tb/tb_ad9945_cfg_ctrl.sv - scoreboard bench for ad9945_cfg_ctrl
module tb_ad9945_cfg_ctrl;

  localparam int INIT_D = 64;
  localparam int XFER   = 56;

  localparam int S_EN    = 0;
  localparam int S_BUSY  = 1;
  localparam int S_HACK  = 2;
  localparam int S_AACK  = 3;
  localparam int S_OPER  = 4;
  localparam int S_CTRL  = 5;
  localparam int S_CLAMP = 6;
  localparam int S_GAIN  = 7;
  localparam int S_CNT   = 8;
  localparam int S_AUX   = 9;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        host_wr = 1'b0;
  logic [1:0]  host_sel = 2'd0;
  logic [9:0]  host_wdata = 10'd0;
  logic        host_ack;
  logic        agc_req = 1'b0;
  logic [9:0]  agc_gain = 10'd0;
  logic        agc_ack;
  logic        frame_sync = 1'b0;
  logic        sync_mode = 1'b0;
  logic [6:0]  Oper;
  logic [6:0]  Ctrl;
  logic [7:0]  Clamp;
  logic [9:0]  VGA_Gain;
  logic        cfg_en;
  logic        busy;
  logic        cfg_done;
  logic [15:0] cfg_count;

  ad9945_cfg_ctrl #(
    .XFER_CYCLES(XFER),
    .INIT_DELAY (INIT_D)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .host_wr   (host_wr),
    .host_sel  (host_sel),
    .host_wdata(host_wdata),
    .host_ack  (host_ack),
    .agc_req   (agc_req),
    .agc_gain  (agc_gain),
    .agc_ack   (agc_ack),
    .frame_sync(frame_sync),
    .sync_mode (sync_mode),
    .Oper      (Oper),
    .Ctrl      (Ctrl),
    .Clamp     (Clamp),
    .VGA_Gain  (VGA_Gain),
    .cfg_en    (cfg_en),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_count (cfg_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [6:0] oper;
    logic [6:0] ctrl;
    logic [7:0] clamp;
    logic [9:0] gain;
  } xfer_t;

  typedef struct {
    int    sig;
    int    exp;
    int    act;
    string name;
  } probe_t;

  xfer_t  sb_q[$];
  probe_t pr_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     sb_skip = 1'b0;
  int     xfers_seen = 0;

  // Monitor: sole owner of the check/error counters.
  probe_t mp;
  xfer_t  me;
  int     mact;
  logic   prev_en = 1'b0;
  int     en_len = 0;
  int     since_rise = 0;
  int     cnt_model = 0;

  initial forever begin
    @(negedge sys_clk);
    while (pr_q.size() > 0) begin
      mp = pr_q.pop_front();
      case (mp.sig)
        S_EN:    mact = int'(cfg_en);
        S_BUSY:  mact = int'(busy);
        S_HACK:  mact = int'(host_ack);
        S_AACK:  mact = int'(agc_ack);
        S_OPER:  mact = int'(Oper);
        S_CTRL:  mact = int'(Ctrl);
        S_CLAMP: mact = int'(Clamp);
        S_GAIN:  mact = int'(VGA_Gain);
        S_CNT:   mact = int'(cfg_count);
        default: mact = mp.act;
      endcase
      checks++;
      if (mact != mp.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", mp.name, mact, mp.exp, $time);
      end
    end
    if (sys_rst) begin
      prev_en    = 1'b0;
      en_len     = 0;
      since_rise = 0;
      cnt_model  = 0;
    end else begin
      if (cfg_en && !prev_en) begin
        since_rise = 0;
        xfers_seen++;
        if (!sb_skip) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected: transfer with oper=%h ctrl=%h clamp=%0d gain=%h, none expected",
                     Oper, Ctrl, Clamp, VGA_Gain);
          end else begin
            me = sb_q.pop_front();
            if (Oper !== me.oper || Ctrl !== me.ctrl || Clamp !== me.clamp || VGA_Gain !== me.gain) begin
              errors++;
              $display("FAIL xfer_regs: got oper=%h ctrl=%h clamp=%0d gain=%h expected oper=%h ctrl=%h clamp=%0d gain=%h",
                       Oper, Ctrl, Clamp, VGA_Gain, me.oper, me.ctrl, me.clamp, me.gain);
            end
          end
        end
      end
      if (cfg_en) en_len++;
      if (!cfg_en && prev_en) begin
        checks++;
        if (en_len != 2) begin
          errors++;
          $display("FAIL cfg_en_width: got %0d expected 2", en_len);
        end
        en_len = 0;
      end
      if (cfg_done) begin
        checks++;
        if (since_rise != XFER + 2) begin
          errors++;
          $display("FAIL rise_to_done: got %0d expected %0d", since_rise, XFER + 2);
        end
        checks++;
        if (cfg_count != 16'(cnt_model)) begin
          errors++;
          $display("FAIL count_at_done: got %0d expected %0d", cfg_count, cnt_model);
        end
        cnt_model++;
      end
      since_rise++;
      prev_en = cfg_en;
    end
  end

  task automatic expect_sig(input int sig, input int exp, input string name);
    probe_t p;
    p.sig = sig; p.exp = exp; p.act = 0; p.name = name;
    pr_q.push_back(p);
  endtask

  task automatic expect_val(input int act, input int exp, input string name);
    probe_t p;
    p.sig = S_AUX; p.exp = exp; p.act = act; p.name = name;
    pr_q.push_back(p);
  endtask

  task automatic push_xfer(input logic [6:0] o, input logic [6:0] c, input logic [7:0] cl, input logic [9:0] g);
    xfer_t x;
    x.oper = o; x.ctrl = c; x.clamp = cl; x.gain = g;
    sb_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [9:0] d);
    host_wr = 1'b1; host_sel = sel; host_wdata = d;
    tick();
    host_wr = 1'b0;
    expect_sig(S_HACK, 1, "host_ack");
  endtask

  task automatic wait_en_rise(input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (!cfg_en && n < budget);
    expect_val(int'(cfg_en), 1, "en_rise_timeout");
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin tick(); n++; end while (!cfg_done && n < budget);
    expect_val(int'(cfg_done), 1, "done_timeout");
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (busy && n < budget);
    expect_val(int'(busy), 0, "idle_timeout");
  endtask

  initial begin
    int n;
    int en_hi;
    int seen0;

    // 1: reset values and power-up transfer
    repeat (3) @(posedge sys_clk);
    #1;
    expect_sig(S_EN, 0, "rst_cfg_en");
    expect_sig(S_BUSY, 1, "rst_busy");
    expect_sig(S_HACK, 0, "rst_host_ack");
    expect_sig(S_AACK, 0, "rst_agc_ack");
    expect_sig(S_OPER, 0, "rst_oper");
    expect_sig(S_CTRL, 0, "rst_ctrl");
    expect_sig(S_CLAMP, 128, "rst_clamp");
    expect_sig(S_GAIN, 0, "rst_gain");
    expect_sig(S_CNT, 0, "rst_count");
    tick();
    push_xfer(7'h00, 7'h00, 8'd128, 10'd0);
    sys_rst = 1'b0;
    wait_en_rise(200, n);
    expect_val(n, INIT_D + 1, "init_latency");
    wait_done(100);
    tick();
    expect_sig(S_CNT, 1, "count_after_init");
    expect_sig(S_BUSY, 0, "idle_after_init");

    // 2: immediate host gain write, latency and occupancy
    push_xfer(7'h00, 7'h00, 8'd128, 10'h2A5);
    host_write(2'd3, 10'h2A5);
    expect_sig(S_BUSY, 0, "e0_still_idle");
    tick();
    expect_sig(S_BUSY, 1, "e1_load_busy");
    expect_sig(S_EN, 0, "e1_load_no_en");
    tick();
    expect_sig(S_EN, 1, "e2_cfg_en");
    expect_sig(S_GAIN, 'h2A5, "e2_gain");
    wait_idle(200, n);
    expect_val(n + 1, XFER + 4, "busy_cycles");
    expect_sig(S_CNT, 2, "count_after_gain");

    // 4: clamp write during WAIT -> back-to-back transfer
    push_xfer(7'h15, 7'h00, 8'd128, 10'h2A5);
    host_write(2'd0, 10'h015);
    wait_en_rise(10, n);
    repeat (20) tick();
    push_xfer(7'h15, 7'h00, 8'd200, 10'h2A5);
    host_write(2'd2, 10'd200);
    expect_sig(S_CLAMP, 128, "clamp_held_in_wait");
    wait_done(100);
    expect_sig(S_CLAMP, 128, "clamp_held_at_done");
    tick();
    expect_sig(S_BUSY, 0, "gap_idle");
    tick();
    expect_sig(S_BUSY, 1, "b2b_load");
    wait_idle(200, n);
    expect_sig(S_CLAMP, 200, "clamp_committed");
    expect_sig(S_CNT, 4, "count_after_b2b");

    // 5: frame-synchronous commit
    sync_mode = 1'b1;
    host_write(2'd3, 10'd50);
    en_hi = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (cfg_en || busy) en_hi++;
    end
    expect_val(en_hi, 0, "sync_hold_off");
    push_xfer(7'h15, 7'h00, 8'd200, 10'd50);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    expect_sig(S_BUSY, 1, "fsync_load");
    wait_en_rise(10, n);
    push_xfer(7'h15, 7'h2B, 8'd200, 10'd50);
    host_write(2'd1, 10'h02B);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    wait_done(100);
    tick();
    expect_sig(S_BUSY, 0, "pend_gap_idle");
    tick();
    expect_sig(S_BUSY, 1, "sync_pend_launch");
    wait_idle(200, n);
    expect_sig(S_CNT, 6, "count_after_sync");
    sync_mode = 1'b0;

    // 3: arbitration, final committed gain only
    sb_skip = 1'b1;
    seen0 = xfers_seen;
    host_wr = 1'b1; host_sel = 2'd3; host_wdata = 10'h100;
    agc_req = 1'b1; agc_gain = 10'h3FF;
    tick();
    host_wr = 1'b0;
    expect_sig(S_HACK, 1, "arb_host_ack");
    expect_sig(S_AACK, 0, "arb_agc_blocked");
    tick();
    expect_sig(S_AACK, 1, "arb_agc_retry");
    agc_req = 1'b0;
    wait_idle(200, n);
    repeat (3) tick();
    wait_idle(200, n);
    expect_sig(S_GAIN, 'h3FF, "arb_final_gain");
    expect_val(int'((xfers_seen - seen0) >= 1 && (xfers_seen - seen0) <= 2), 1, "arb_xfer_count");
    host_wr = 1'b1; host_sel = 2'd1; host_wdata = 10'h011;
    agc_req = 1'b1; agc_gain = 10'h155;
    tick();
    host_wr = 1'b0; agc_req = 1'b0;
    expect_sig(S_HACK, 1, "both_host_ack");
    expect_sig(S_AACK, 1, "both_agc_ack");
    wait_idle(200, n);
    expect_sig(S_CTRL, 'h11, "both_ctrl");
    expect_sig(S_GAIN, 'h155, "both_gain");
    tick();
    sb_skip = 1'b0;

    // 6: reset during WAIT
    push_xfer(7'h7F, 7'h11, 8'd200, 10'h155);
    host_write(2'd0, 10'h07F);
    wait_en_rise(10, n);
    repeat (10) tick();
    #2;
    sys_rst = 1'b1;
    #1;
    expect_sig(S_EN, 0, "midrst_cfg_en");
    expect_sig(S_OPER, 0, "midrst_oper");
    expect_sig(S_CTRL, 0, "midrst_ctrl");
    expect_sig(S_CLAMP, 128, "midrst_clamp");
    expect_sig(S_GAIN, 0, "midrst_gain");
    expect_sig(S_CNT, 0, "midrst_count");
    expect_sig(S_BUSY, 1, "midrst_busy");
    tick();
    push_xfer(7'h00, 7'h00, 8'd128, 10'd0);
    sys_rst = 1'b0;
    wait_en_rise(200, n);
    expect_val(n, INIT_D + 1, "reinit_latency");
    wait_done(100);
    tick();
    expect_sig(S_CNT, 1, "count_after_reinit");
    expect_val(sb_q.size(), 0, "scoreboard_drained");
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
